// File: rtl/upsample_unpool.sv
// 2x upsampler: buffers one row of pooled 3-channel pixels, then emits each output row twice.
// Optional macro UPSAMPLE_ZERO_INSERT_EN selects zero-insertion instead of nearest-neighbour.
module upsample_unpool #(
  parameter int unsigned CONV_BIT        = 12,
  parameter int unsigned HALF_WIDTH      = 12,
  parameter int unsigned HALF_HEIGHT     = 12,
  parameter int unsigned HALF_WIDTH_BIT  = 4,
  parameter int unsigned HALF_HEIGHT_BIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [CONV_BIT-1:0] pool_in_1,
  input  logic [CONV_BIT-1:0] pool_in_2,
  input  logic [CONV_BIT-1:0] pool_in_3,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [CONV_BIT-1:0] up_value_1,
  output logic [CONV_BIT-1:0] up_value_2,
  output logic [CONV_BIT-1:0] up_value_3,
  output logic                frame_done
);

  typedef enum logic [1:0] {StLoad, StEmit0, StEmit1} state_e;

  localparam logic [HALF_WIDTH_BIT-1:0]  ColLast = HALF_WIDTH_BIT'(HALF_WIDTH - 1);
  localparam logic [HALF_HEIGHT_BIT-1:0] RowLast = HALF_HEIGHT_BIT'(HALF_HEIGHT - 1);

  state_e                     state_q, state_d;
  logic [HALF_WIDTH_BIT-1:0]  col_q, col_d;
  logic [HALF_WIDTH_BIT-1:0]  pix_q, pix_d;
  logic                       half_q, half_d;
  logic [HALF_HEIGHT_BIT-1:0] row_q, row_d;
  logic                       valid_out_q, valid_out_d;
  logic                       frame_done_q, frame_done_d;
  logic [CONV_BIT-1:0]        up_1_q, up_1_d, up_2_q, up_2_d, up_3_q, up_3_d;
  logic                       present;
  logic                       zero;

  logic [CONV_BIT-1:0] row_buf_1_q [HALF_WIDTH];
  logic [CONV_BIT-1:0] row_buf_2_q [HALF_WIDTH];
  logic [CONV_BIT-1:0] row_buf_3_q [HALF_WIDTH];

  assign ready_in   = (state_q == StLoad);
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;
  assign up_value_1 = up_1_q;
  assign up_value_2 = up_2_q;
  assign up_value_3 = up_3_q;

  always_ff @(posedge clk) begin
    if (ready_in && valid_in) begin
      row_buf_1_q[col_q] <= pool_in_1;
      row_buf_2_q[col_q] <= pool_in_2;
      row_buf_3_q[col_q] <= pool_in_3;
    end
  end

  // Output beat k maps to pixel pix = k>>1 and phase half = k[0].
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    pix_d        = pix_q;
    half_d       = half_q;
    row_d        = row_q;
    valid_out_d  = valid_out_q;
    frame_done_d = 1'b0;
    present      = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (valid_in) begin
          if (col_q == ColLast) begin
            col_d       = '0;
            pix_d       = '0;
            half_d      = 1'b0;
            state_d     = StEmit0;
            valid_out_d = 1'b1;
            present     = 1'b1;
          end else begin
            col_d = col_q + HALF_WIDTH_BIT'(1);
          end
        end
      end
      StEmit0, StEmit1: begin
        if (ready_out) begin
          present = 1'b1;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (pix_q != ColLast) begin
              pix_d = pix_q + HALF_WIDTH_BIT'(1);
            end else begin
              pix_d = '0;
              if (state_q == StEmit0) begin
                state_d = StEmit1;
              end else begin
                state_d     = StLoad;
                valid_out_d = 1'b0;
                present     = 1'b0;
                if (row_q == RowLast) begin
                  row_d        = '0;
                  frame_done_d = 1'b1;
                end else begin
                  row_d = row_q + HALF_HEIGHT_BIT'(1);
                end
              end
            end
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

`ifdef UPSAMPLE_ZERO_INSERT_EN
  // Only the top-left beat of each 2x2 block carries data.
  assign zero = (state_d == StEmit1) || half_d;
`else
  assign zero = 1'b0;
`endif

  always_comb begin
    up_1_d = up_1_q;
    up_2_d = up_2_q;
    up_3_d = up_3_q;
    if (present) begin
      up_1_d = zero ? '0 : row_buf_1_q[pix_d];
      up_2_d = zero ? '0 : row_buf_2_q[pix_d];
      up_3_d = zero ? '0 : row_buf_3_q[pix_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StLoad;
      col_q        <= '0;
      pix_q        <= '0;
      half_q       <= 1'b0;
      row_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      up_1_q       <= '0;
      up_2_q       <= '0;
      up_3_q       <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      pix_q        <= pix_d;
      half_q       <= half_d;
      row_q        <= row_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      up_1_q       <= up_1_d;
      up_2_q       <= up_2_d;
      up_3_q       <= up_3_d;
    end
  end

endmodule

// File: tb/tb_upsample_unpool.sv
// Randomized bench for upsample_unpool against a row/frame-level reference model.
module tb_upsample_unpool;

  localparam int HW = 12;
  localparam int HH = 3;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [11:0] pool_in_1, pool_in_2, pool_in_3;
  logic        valid_out;
  logic        ready_out;
  logic [11:0] up_value_1, up_value_2, up_value_3;
  logic        frame_done;

  upsample_unpool #(
    .CONV_BIT       (12),
    .HALF_WIDTH     (HW),
    .HALF_HEIGHT    (HH),
    .HALF_WIDTH_BIT (4),
    .HALF_HEIGHT_BIT(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .pool_in_1 (pool_in_1),
    .pool_in_2 (pool_in_2),
    .pool_in_3 (pool_in_3),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .up_value_1(up_value_1),
    .up_value_2(up_value_2),
    .up_value_3(up_value_3),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state (owned by the monitor process).
  logic [35:0] exp_q[$];
  logic [35:0] row_pix[$];
  int          beats = 0;
  int          frames = 0;
  int          pend = 0;
  logic        fd_exp = 1'b0;
  logic        was_rst = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      check("valid_out", valid_out, exp_q.size() != 0);
      check("ready_in", ready_in, exp_q.size() == 0);
      check("frame_done", frame_done, fd_exp);
      if (was_rst) begin
        check("rst_up", {up_value_1, up_value_2, up_value_3}, 36'h0);
      end
      if (valid_out && exp_q.size() != 0) begin
        check("beat", {up_value_1, up_value_2, up_value_3}, exp_q[0]);
      end
      fd_exp = 1'b0;
      if (!rst_n) begin
        exp_q.delete();
        row_pix.delete();
        beats   = 0;
        was_rst = 1'b1;
      end else begin
        was_rst = 1'b0;
        if (valid_in && exp_q.size() == 0) begin
          row_pix.push_back({pool_in_1, pool_in_2, pool_in_3});
          if (row_pix.size() == HW) begin
            // Two output rows, each pixel doubled horizontally.
            for (int y = 0; y < 2; y++) begin
              for (int x = 0; x < 2 * HW; x++) begin
`ifdef UPSAMPLE_ZERO_INSERT_EN
                exp_q.push_back((y == 0 && x % 2 == 0) ? row_pix[x / 2] : 36'h0);
`else
                exp_q.push_back(row_pix[x / 2]);
`endif
              end
            end
            row_pix.delete();
          end
        end else if (valid_out && ready_out && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          beats++;
          if (beats == 4 * HW * HH) begin
            fd_exp = 1'b1;
            beats  = 0;
            frames++;
          end
        end
      end
      pend = exp_q.size();
    end
  end

  // Downstream ready: 0 = always, 1 = random, 2 = pattern 1,0,0,1.
  int rdy_mode = 0;
  initial begin
    int cyc;
    cyc = 0;
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready_out = 1'b1;
        1:       ready_out = 1'($urandom_range(0, 1));
        default: ready_out = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      cyc++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the pixel was accepted.
  task automatic send_pix(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                          input int max_gap);
    logic acc;
    int   n;
    valid_in = 1'b0;
    repeat ($urandom_range(0, max_gap)) begin
      @(posedge clk);
      #1;
    end
    valid_in  = 1'b1;
    pool_in_1 = a;
    pool_in_2 = b;
    pool_in_3 = c;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    valid_in = 1'b0;
  endtask

  task automatic send_row(input int r, input bit directed, input int max_gap);
    for (int c = 0; c < HW; c++) begin
      if (directed) begin
        send_pix(12'(r * HW + c + 1), 12'hF80, 12'(~(r * 16 + c)), max_gap);
      end else begin
        send_pix(12'($urandom), 12'($urandom), 12'($urandom), max_gap);
      end
    end
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    pool_in_1 = '0;
    pool_in_2 = '0;
    pool_in_3 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed frame, back-to-back input held valid through emit, no backpressure.
    rdy_mode = 0;
    for (int r = 0; r < HH; r++) send_row(r, 1'b1, 0);

    // Reset after one pixel of a row.
    rdy_mode = 2;
    send_pix(12'h9, 12'h9, 12'h9, 0);
    do_reset();

    // Reset in the middle of an emit.
    rdy_mode = 1;
    send_row(0, 1'b0, 1);
    repeat (5) @(posedge clk);
    #1;
    do_reset();

    // Three full frames under different traffic shapes.
    rdy_mode = 2;
    for (int r = 0; r < HH; r++) send_row(r, 1'b0, 0);
    rdy_mode = 1;
    for (int r = 0; r < HH; r++) send_row(r, 1'b0, 2);
    rdy_mode = 0;
    for (int r = 0; r < HH; r++) send_row(r, 1'b1, 1);

    for (int i = 0; i < 2000 && pend != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("drained", 64'(pend), 64'd0);
    check("frames", 64'(frames), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
